// File: rtl/ps2_cmd_arbiter.sv
// Round-robin arbiter sharing the keyboard_controller command port between N_REQ requesters.
// Issues one command at a time, re-issues on Resend (0xFE), and bounds each attempt with a timeout.
module ps2_cmd_arbiter #(
    parameter int N_REQ          = 3,
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_cmd,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_accept,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [7:0]         resp_result,
    output logic               resp_err,
    output logic [7:0]         kb_cmd,
    output logic [7:0]         kb_cmd_data,
    output logic               kb_cmd_exec,
    input  logic [7:0]         kb_cmd_result,
    input  logic               kb_cmd_complete,
    input  logic               kb_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RT_W-1:0]  RETRY_MAX  = RT_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(N_REQ - 1);
    localparam logic [7:0]       RES_RESEND = 8'hFE;
    localparam logic [7:0]       RES_FAIL   = 8'hFC;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_REISSUE   = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [IDX_W-1:0]  grant_r;
    logic [IDX_W-1:0]  last_grant_r;
    logic [RT_W-1:0]   retry_r;
    logic [TO_W-1:0]   tmo_r;

    logic              hi_found_s;
    logic              lo_found_s;
    logic [IDX_W-1:0]  hi_idx_s;
    logic [IDX_W-1:0]  lo_idx_s;
    logic              win_found_s;
    logic [IDX_W-1:0]  win_idx_s;

    logic              grant_s;
    logic              tmo_clr_s;
    logic              tmo_inc_s;
    logic              retry_inc_s;
    logic              resp_load_s;
    logic [7:0]        resp_result_s;
    logic              resp_err_s;

    // Round-robin pick: lowest requester above last_grant, else lowest at or below it (wrap).
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            hi_found_s = hi_found_s | (req_valid[i] && (i > int'(last_grant_r)));
            lo_found_s = lo_found_s | (req_valid[i] && (i <= int'(last_grant_r)));
            hi_idx_s   = (req_valid[i] && (i > int'(last_grant_r)))  ? IDX_W'(i) : hi_idx_s;
            lo_idx_s   = (req_valid[i] && (i <= int'(last_grant_r))) ? IDX_W'(i) : lo_idx_s;
        end
        win_found_s = hi_found_s | lo_found_s;
        win_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // Next-state and datapath control; a completion beats a timeout in the same cycle.
    always_comb begin
        next_state_s  = state_r;
        grant_s       = 1'b0;
        tmo_clr_s     = 1'b0;
        tmo_inc_s     = 1'b0;
        retry_inc_s   = 1'b0;
        resp_load_s   = 1'b0;
        resp_result_s = 8'h00;
        resp_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!kb_busy && win_found_s) begin
                    grant_s      = 1'b1;
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (tmo_r == TO_LAST) begin
                    resp_load_s   = 1'b1;
                    resp_result_s = 8'h00;
                    resp_err_s    = 1'b1;
                    next_state_s  = ST_RESPOND;
                end else if (kb_busy) begin
                    tmo_inc_s    = 1'b1;
                    next_state_s = ST_WAIT_DONE;
                end else begin
                    tmo_inc_s    = 1'b1;
                    next_state_s = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (kb_cmd_complete) begin
                    if ((kb_cmd_result == RES_RESEND) && (retry_r < RETRY_MAX)) begin
                        retry_inc_s  = 1'b1;
                        next_state_s = ST_REISSUE;
                    end else begin
                        resp_load_s   = 1'b1;
                        resp_result_s = kb_cmd_result;
                        resp_err_s    = (kb_cmd_result == RES_RESEND) || (kb_cmd_result == RES_FAIL);
                        next_state_s  = ST_RESPOND;
                    end
                end else if (tmo_r == TO_LAST) begin
                    resp_load_s   = 1'b1;
                    resp_result_s = 8'h00;
                    resp_err_s    = 1'b1;
                    next_state_s  = ST_RESPOND;
                end else begin
                    tmo_inc_s    = 1'b1;
                    next_state_s = ST_WAIT_DONE;
                end
            end
            ST_REISSUE: begin
                if (!kb_busy) begin
                    tmo_clr_s    = 1'b1;
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_REISSUE;
                end
            end
            ST_RESPOND: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs, latched command, and the retry/timeout counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r      <= '0;
            last_grant_r <= LAST_INIT;
            retry_r      <= '0;
            tmo_r        <= '0;
            req_accept   <= '0;
            resp_valid   <= '0;
            resp_result  <= 8'h00;
            resp_err     <= 1'b0;
            kb_cmd       <= 8'h00;
            kb_cmd_data  <= 8'h00;
            kb_cmd_exec  <= 1'b0;
        end else begin
            kb_cmd_exec <= (next_state_s == ST_ISSUE);
            req_accept  <= grant_s ? (N_REQ'(1'b1) << win_idx_s) : '0;
            resp_valid  <= resp_load_s ? (N_REQ'(1'b1) << grant_r) : '0;
            if (grant_s) begin
                grant_r     <= win_idx_s;
                kb_cmd      <= req_cmd[{win_idx_s, 3'b000} +: 8];
                kb_cmd_data <= req_data[{win_idx_s, 3'b000} +: 8];
            end
            if (grant_s || tmo_clr_s) begin
                tmo_r <= '0;
            end else if (tmo_inc_s) begin
                tmo_r <= tmo_r + TO_W'(1);
            end
            if (grant_s) begin
                retry_r <= '0;
            end else if (retry_inc_s) begin
                retry_r <= retry_r + RT_W'(1);
            end
            if (resp_load_s) begin
                resp_result  <= resp_result_s;
                resp_err     <= resp_err_s;
                last_grant_r <= grant_r;
            end
        end
    end

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Scoreboard bench for ps2_cmd_arbiter with a scripted keyboard_controller model.
// Expected accepts/responses are queued when a request is driven and popped when the DUT pulses.
module tb_ps2_cmd_arbiter;

    localparam int N   = 3;
    localparam int TMO = 64;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_cmd;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_accept;
    logic [N-1:0]   resp_valid;
    logic [7:0]     resp_result;
    logic           resp_err;
    logic [7:0]     kb_cmd;
    logic [7:0]     kb_cmd_data;
    logic           kb_cmd_exec;
    logic [7:0]     kb_cmd_result;
    logic           kb_cmd_complete;
    logic           kb_busy;
    logic           model_busy;
    logic           force_busy;

    assign kb_busy = model_busy | force_busy;

    ps2_cmd_arbiter #(
        .N_REQ          (N),
        .MAX_RETRY      (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_cmd         (req_cmd),
        .req_data        (req_data),
        .req_accept      (req_accept),
        .resp_valid      (resp_valid),
        .resp_result     (resp_result),
        .resp_err        (resp_err),
        .kb_cmd          (kb_cmd),
        .kb_cmd_data     (kb_cmd_data),
        .kb_cmd_exec     (kb_cmd_exec),
        .kb_cmd_result   (kb_cmd_result),
        .kb_cmd_complete (kb_cmd_complete),
        .kb_busy         (kb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] cmd;
        logic [7:0] data;
    } acc_t;

    typedef struct {
        int         idx;
        logic [7:0] res;
        logic       err;
        int         mode;   // 0: one cycle after complete, 1: TMO cycles after exec rise
    } rsp_t;

    acc_t       exp_acc_q[$];
    rsp_t       exp_resp_q[$];
    logic [7:0] kb_resp_q[$];

    int vectors       = 0;
    int miscompares   = 0;
    int cyc           = 0;
    int comp_dly      = 20;
    bit no_complete   = 1'b0;
    int exec_rises    = 0;
    int exec_rise_cyc = 0;
    int comp_cyc      = 0;
    int acc_cnt       = 0;
    int resp_cnt      = 0;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Keyboard model: busy 3 cycles after exec, complete comp_dly cycles after exec.
    initial begin
        bit aborted;
        model_busy      = 1'b0;
        kb_cmd_complete = 1'b0;
        kb_cmd_result   = 8'h00;
        forever begin
            @(negedge clk);
            if (kb_cmd_exec === 1'b1 && rst === 1'b0) begin
                aborted = 1'b0;
                for (int c = 1; c <= comp_dly && !aborted; c++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                    if (c == 3 && !aborted) model_busy = 1'b1;
                end
                if (!aborted && !no_complete) begin
                    if (kb_resp_q.size() > 0) kb_cmd_result = kb_resp_q.pop_front();
                    else kb_cmd_result = 8'hFA;
                    kb_cmd_complete = 1'b1;
                    comp_cyc = cyc;
                    @(negedge clk);
                    kb_cmd_complete = 1'b0;
                end
                model_busy = 1'b0;
                if (aborted) kb_resp_q.delete();
            end
        end
    end

    // Monitor: pops the scoreboard on every accept/response pulse.
    initial begin
        logic exec_prev;
        acc_t a;
        rsp_t r;
        exec_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (kb_cmd_exec === 1'b1 && !exec_prev) begin
                exec_rises++;
                exec_rise_cyc = cyc;
            end
            exec_prev = (kb_cmd_exec === 1'b1);
            if ((|req_accept) === 1'b1) begin
                acc_cnt++;
                if (exp_acc_q.size() > 0) begin
                    a = exp_acc_q.pop_front();
                    chk("acc_onehot", 32'(req_accept), 32'd1 << a.idx);
                    chk("acc_kb_cmd", 32'(kb_cmd), 32'(a.cmd));
                    chk("acc_kb_data", 32'(kb_cmd_data), 32'(a.data));
                    chk("acc_exec_high", 32'(kb_cmd_exec), 32'd1);
                end else begin
                    chk("spurious_acc", 32'(req_accept), 32'd0);
                end
            end
            if ((|resp_valid) === 1'b1) begin
                resp_cnt++;
                if (exp_resp_q.size() > 0) begin
                    r = exp_resp_q.pop_front();
                    chk("resp_onehot", 32'(resp_valid), 32'd1 << r.idx);
                    chk("resp_result", 32'(resp_result), 32'(r.res));
                    chk("resp_err", 32'(resp_err), 32'(r.err));
                    chk("resp_exec_low", 32'(kb_cmd_exec), 32'd0);
                    if (r.mode == 0) chk("resp_latency", cyc - comp_cyc, 32'd1);
                    else chk("timeout_latency", cyc - exec_rise_cyc, TMO);
                end else begin
                    chk("spurious_resp", 32'(resp_valid), 32'd0);
                end
            end
        end
    end

    task automatic expect_acc(input int idx, input logic [7:0] c, input logic [7:0] d);
        acc_t a;
        a.idx = idx; a.cmd = c; a.data = d;
        exp_acc_q.push_back(a);
    endtask

    task automatic expect_resp(input int idx, input logic [7:0] res, input logic err, input int mode);
        rsp_t r;
        r.idx = idx; r.res = res; r.err = err; r.mode = mode;
        exp_resp_q.push_back(r);
    endtask

    task automatic raise_req(input int idx, input logic [7:0] c, input logic [7:0] d);
        req_cmd[8*idx +: 8]  = c;
        req_data[8*idx +: 8] = d;
        req_valid[idx]       = 1'b1;
    endtask

    task automatic wait_accept(output int g);
        int n;
        g = -1;
        n = 0;
        while (g < 0 && n < 300) begin
            @(negedge clk);
            n++;
            for (int k = 0; k < N; k++) if (req_accept[k] === 1'b1) g = k;
        end
        chk("accept_wait", 32'(g >= 0), 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_resp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("resp_drain", exp_resp_q.size(), 32'd0);
    endtask

    task automatic run_req(input int idx, input logic [7:0] c, input logic [7:0] d,
                           input logic [7:0] res, input logic err, input int mode);
        int g;
        expect_acc(idx, c, d);
        expect_resp(idx, res, err, mode);
        raise_req(idx, c, d);
        wait_accept(g);
        req_valid[idx] = 1'b0;
        wait_drain();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int g;
        int e0;
        int a0;
        int r0;
        int n;
        int left [3];
        rst        = 1'b1;
        req_valid  = '0;
        req_cmd    = '0;
        req_data   = '0;
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", {kb_cmd, kb_cmd_data, resp_result, resp_err, kb_cmd_exec,
                              req_accept, resp_valid}, 32'd0);

        // Basic command
        e0 = exec_rises;
        kb_resp_q.push_back(8'hFA);
        run_req(0, 8'hF4, 8'h00, 8'hFA, 1'b0, 0);
        chk("basic_execs", exec_rises - e0, 32'd1);

        // Round-robin with all three requesters continuously valid
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                expect_acc(i, 8'hF0 + 8'(i), 8'hA0 + 8'(i));
                expect_resp(i, 8'hFA, 1'b0, 0);
            end
        end
        for (int i = 0; i < N; i++) begin
            left[i] = 2;
            raise_req(i, 8'hF0 + 8'(i), 8'hA0 + 8'(i));
        end
        for (int k = 0; k < 2 * N; k++) begin
            wait_accept(g);
            if (g >= 0) begin
                req_valid[g] = 1'b0;
                left[g]--;
                @(negedge clk);
                if (left[g] > 0) req_valid[g] = 1'b1;
            end
        end
        req_valid = '0;
        wait_drain();

        // Retry: two Resends then success, then Resend exhausted, then 0xFC
        e0 = exec_rises;
        kb_resp_q.push_back(8'hFE); kb_resp_q.push_back(8'hFE); kb_resp_q.push_back(8'hFA);
        run_req(1, 8'hED, 8'h02, 8'hFA, 1'b0, 0);
        chk("retry_execs", exec_rises - e0, 32'd3);
        e0 = exec_rises;
        kb_resp_q.push_back(8'hFE); kb_resp_q.push_back(8'hFE); kb_resp_q.push_back(8'hFE);
        run_req(1, 8'hED, 8'h07, 8'hFE, 1'b1, 0);
        chk("retry_exhaust_execs", exec_rises - e0, 32'd3);
        kb_resp_q.push_back(8'hFC);
        run_req(2, 8'hF3, 8'h20, 8'hFC, 1'b1, 0);

        // Timeout: busy but never complete
        no_complete = 1'b1;
        comp_dly    = 80;
        run_req(2, 8'hF2, 8'h00, 8'h00, 1'b1, 1);
        n = 0;
        while (kb_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_release", 32'(kb_busy), 32'd0);
        no_complete = 1'b0;

        // Completion on the same cycle the timeout expires
        comp_dly = TMO - 1;
        kb_resp_q.push_back(8'hFA);
        run_req(1, 8'hF5, 8'h00, 8'hFA, 1'b0, 0);
        comp_dly = 20;

        // Busy held in IDLE blocks the grant
        expect_acc(0, 8'hF6, 8'h11);
        expect_resp(0, 8'hFA, 1'b0, 0);
        force_busy = 1'b1;
        a0 = acc_cnt;
        raise_req(0, 8'hF6, 8'h11);
        repeat (10) @(negedge clk);
        chk("busy_no_accept", acc_cnt - a0, 32'd0);
        force_busy = 1'b0;
        wait_accept(g);
        req_valid = '0;
        wait_drain();

        // Reset during WAIT_DONE drops the command; requester 0 wins afterwards
        expect_acc(1, 8'hF2, 8'h00);
        raise_req(1, 8'hF2, 8'h00);
        wait_accept(g);
        req_valid = '0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {kb_cmd, kb_cmd_data, resp_result, resp_err, kb_cmd_exec,
                                 req_accept, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        r0 = resp_cnt;
        repeat (30) @(negedge clk);
        chk("midreset_no_resp", resp_cnt - r0, 32'd0);
        expect_acc(0, 8'hF4, 8'h00);
        expect_resp(0, 8'hFA, 1'b0, 0);
        raise_req(2, 8'hF4, 8'h02);
        raise_req(1, 8'hF4, 8'h01);
        raise_req(0, 8'hF4, 8'h00);
        wait_accept(g);
        req_valid = '0;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ps2_cmd_arbiter.md
# ps2_cmd_arbiter

Shares the single command port of `keyboard_controller` (`cmd`, `cmd_data`, `cmd_exec`, `cmd_result`, `cmd_complete`, `busy`) between N independent requesters, such as the init sequencer, LED updater and typematic-rate setter. It arbitrates round-robin and drives the exec/busy/complete handshake. It re-issues a command when the keyboard answers Resend (0xFE), enforces a timeout, and returns one result per accepted request. It sits between the top-level sequencing logic and `keyboard_controller`.

## Interface
- `N_REQ`, 3: number of requesters (1..8).
- `MAX_RETRY`, 2: re-issues allowed after a 0xFE result.
- `TIMEOUT_CYCLES`, 1000000: cycles allowed per attempt, counted from entering ISSUE; the counter width is clog2(TIMEOUT_CYCLES).
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_cmd` in 8*N_REQ: command byte; requester i uses `[8i+7:8i]`.
- `req_data` in 8*N_REQ: command data byte, same packing.
- `req_accept` out N_REQ: one-cycle pulse; the request has been latched.
- `resp_valid` out N_REQ: one-cycle pulse to the granted requester; the result is ready.
- `resp_result` out 8: final `cmd_result`, or 0x00 on timeout; held until the next response.
- `resp_err` out 1: 1 on timeout, on 0xFC, or when retries are exhausted; held like `resp_result`.
- `kb_cmd` out 8, `kb_cmd_data` out 8: connect to `keyboard_controller` `cmd` / `cmd_data`.
- `kb_cmd_exec` out 1: connects to `cmd_exec`.
- `kb_cmd_result` in 8, `kb_cmd_complete` in 1, `kb_busy` in 1: connect to `cmd_result`, `cmd_complete` and `busy`.

## Operation
States are IDLE, ISSUE, WAIT_DONE, REISSUE and RESPOND.

**IDLE**
- A grant is made only when `kb_busy`=0 and `req_valid`≠0.
- Round-robin: the winner is the first set bit searching upward from `last_grant+1`, wrapping at N_REQ.
- On a grant: latch `req_cmd`/`req_data` of the winner into `kb_cmd`/`kb_cmd_data`, store the winner index g, clear the retry and timeout counters, then go to ISSUE.
- `req_accept[g]` is a registered pulse that is high in the first ISSUE cycle.
- The requester must drop or replace `req_valid` in the cycle it sees `req_accept`.

**ISSUE**
- `kb_cmd_exec`=1.
- On `kb_busy`=1: go to WAIT_DONE; `kb_cmd_exec`=0 from that cycle.

**WAIT_DONE**
- On `kb_cmd_complete`=1, capture `kb_cmd_result`, then:
  - 0xFE with retries < MAX_RETRY: retries+1, go to REISSUE.
  - 0xFE with retries = MAX_RETRY: go to RESPOND, err=1, result=0xFE.
  - 0xFC: go to RESPOND, err=1.
  - Any other value: go to RESPOND, err=0.

**REISSUE**
- Wait for `kb_busy`=0, then clear the timeout counter and go to ISSUE.
- `req_accept` is not pulsed again.

**Timeout**
- The timeout counter increments every cycle in ISSUE and WAIT_DONE.
- When it reaches TIMEOUT_CYCLES-1: go to RESPOND, result=0x00, err=1, `kb_cmd_exec`=0.
- If `kb_cmd_complete` and the timeout occur in the same cycle, the complete wins.

**RESPOND**
- Update `resp_result`/`resp_err`, pulse `resp_valid[g]` for one cycle, set `last_grant`=g, return to IDLE.

**Reset**
- All outputs reset to 0.
- `last_grant` resets to N_REQ-1, so requester 0 wins first.
- State resets to IDLE and counters to 0.
- Reset mid-command: `kb_cmd_exec` drops in the cycle after the reset edge and no `resp_valid` is generated. The in-flight request is lost; requesters resubmit.

## Timing
- Edge T samples IDLE with a valid request: `req_accept[g]`=1 and `kb_cmd_exec`=1 in cycle T+1.
- `kb_busy` sampled high at edge B: `kb_cmd_exec`=0 from B+1.
- `kb_cmd_complete` sampled at edge C with a non-retry result: `resp_valid[g]`, `resp_result` and `resp_err` are valid in cycle C+1. The state is IDLE at C+2, and the earliest next grant is sampled at edge C+2.
- Retry path: C → REISSUE → ISSUE, with a minimum of 2 cycles before `kb_cmd_exec` is reasserted.
- Maximum attempts per request: MAX_RETRY+1.
- At most one command is outstanding, and `req_accept` and `resp_valid` never pulse for different requesters in the same cycle.

## Test plan
- Basic command:
  - Stimulus: `rst` for 2 cycles; req0 sends cmd 0xF4; the bench model raises busy 3 cycles after exec and completes after 20 cycles with 0xFA.
  - Required response: one `req_accept[0]` pulse, then `resp_valid[0]` with result 0xFA and err=0, 1 cycle after complete.
- Round-robin:
  - Stimulus: req0, req1 and req2 all valid continuously (each re-asserts after its accept); every command completes with 0xFA.
  - Required response: grant order is 0,1,2,0,1,2, and each response pulses only the matching `resp_valid` bit.
- Retry:
  - Stimulus: req1 sends 0xED/0x02; the model answers 0xFE, 0xFE, 0xFA.
  - Required response: exactly 3 exec assertions and one `resp_valid[1]` with result 0xFA, err=0.
  - Variant: the model answers 0xFE three times. Required response: result 0xFE, err=1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=64; the model raises busy but never completes.
  - Required response: `resp_valid` 64 cycles after ISSUE entry, with result 0x00 and err=1; `kb_cmd_exec` is low.
- Busy and reset:
  - Stimulus 1: `kb_busy` held high in IDLE with req0 valid. Required response: no `req_accept`.
  - Stimulus 2: assert `rst` during WAIT_DONE. Required response: all outputs are 0 the next cycle, no `resp_valid` is produced, and requester 0 wins the next grant.
- Same-cycle tie:
  - Stimulus: `kb_cmd_complete` with 0xFA arrives on the same cycle the timeout expires.
  - Required response: result 0xFA, err=0.
